tictactoe_game_ctrl: RTL

Game-logic stage that sits directly upstream of the VGA tic-tac-toe renderer and downstream of gamepad_pmod_single.
- Consumes decoded gamepad button levels.
- Maintains the 3x3 board, current turn and cursor; the renderer draws from this state.
- Evaluates win/draw with a sequential line scanner and exposes the result for on-screen highlighting.

---
 rtl/tictactoe_pkg.sv | 38 +++
 rtl/tictactoe_press_detect.sv | 26 ++
 rtl/tictactoe_game_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/tictactoe_pkg.sv
// Shared types and constants for the tic-tac-toe game controller.
// Button bit order in press/level vectors: up, down, left, right, a, start (LSB first).
package tictactoe_pkg;

    typedef enum logic [1:0] {
        StPlay  = 2'd0,
        StCheck = 2'd1,
        StWin   = 2'd2,
        StDraw  = 2'd3
    } game_state_e;

    localparam int unsigned CELL_COUNT  = 9;
    localparam logic [3:0]  CURSOR_INIT = 4'd4;

    localparam int unsigned BTN_UP    = 0;
    localparam int unsigned BTN_DOWN  = 1;
    localparam int unsigned BTN_LEFT  = 2;
    localparam int unsigned BTN_RIGHT = 3;
    localparam int unsigned BTN_A     = 4;
    localparam int unsigned BTN_START = 5;

    // Rows, then columns, then the two diagonals; bit i is cell row*3+col.
    localparam logic [CELL_COUNT-1:0] LINE_MASK [0:7] = '{
        9'b000000111,
        9'b000111000,
        9'b111000000,
        9'b001001001,
        9'b010010010,
        9'b100100100,
        9'b100010001,
        9'b001010100
    };

    function automatic logic [3:0] cell_index(input logic [1:0] row, input logic [1:0] col);
        return {2'b00, row} * 4'd3 + {2'b00, col};
    endfunction

endpackage

// File: rtl/tictactoe_press_detect.sv
// Rising-edge detector for the six gamepad buttons, gated by controller presence.
module tictactoe_press_detect (
    input  logic       clk,
    input  logic       reset,
    input  logic       pad_present,
    input  logic [5:0] level,
    output logic [5:0] press
);

    logic [5:0] prev_q, prev_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= '1;
        end else begin
            prev_q <= prev_d;
        end
    end

    // History forced high while disconnected so a held button cannot fire on reconnect.
    always_comb begin
        prev_d = pad_present ? level : '1;
        press  = pad_present ? (level & ~prev_q) : '0;
    end

endmodule

// File: rtl/tictactoe_game_ctrl.sv
// Tic-tac-toe game logic: board, turn and cursor state plus a one-line-per-cycle win scanner.
module tictactoe_game_ctrl
    import tictactoe_pkg::*;
#(
    parameter logic        START_TURN  = 1'b0,
    parameter int unsigned CURSOR_WRAP = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pad_present,
    input  logic                  btn_up,
    input  logic                  btn_down,
    input  logic                  btn_left,
    input  logic                  btn_right,
    input  logic                  btn_a,
    input  logic                  btn_start,
    output logic [CELL_COUNT-1:0] cell_occupied,
    output logic [CELL_COUNT-1:0] cell_is_circle,
    output logic                  turn,
    output logic [3:0]            cursor,
    output logic [1:0]            game_state,
    output logic                  winner,
    output logic [CELL_COUNT-1:0] win_mask
);

    localparam bit Wrap = (CURSOR_WRAP != 0);

    game_state_e           state_q, state_d;
    logic [CELL_COUNT-1:0] occ_q, occ_d, circ_q, circ_d, win_mask_q, win_mask_d;
    logic                  turn_q, turn_d, winner_q, winner_d;
    logic [3:0]            cursor_q, cursor_d;
    logic [2:0]            line_idx_q, line_idx_d;

    logic [5:0]            press;
    logic [1:0]            row, col, row_n, col_n;
    logic [CELL_COUNT-1:0] mover_cells;
    logic                  line_hit;

    tictactoe_press_detect u_press_detect (
        .clk         (clk),
        .reset       (reset),
        .pad_present (pad_present),
        .level       ({btn_start, btn_a, btn_right, btn_left, btn_down, btn_up}),
        .press       (press)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StPlay;
            occ_q      <= '0;
            circ_q     <= '0;
            turn_q     <= START_TURN;
            cursor_q   <= CURSOR_INIT;
            winner_q   <= 1'b0;
            win_mask_q <= '0;
            line_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            circ_q     <= circ_d;
            turn_q     <= turn_d;
            cursor_q   <= cursor_d;
            winner_q   <= winner_d;
            win_mask_q <= win_mask_d;
            line_idx_q <= line_idx_d;
        end
    end

    always_comb begin
        row = 2'd0;
        col = 2'd0;
        case (cursor_q)
            4'd0, 4'd1, 4'd2: row = 2'd0;
            4'd3, 4'd4, 4'd5: row = 2'd1;
            default:          row = 2'd2;
        endcase
        case (cursor_q)
            4'd0, 4'd3, 4'd6: col = 2'd0;
            4'd1, 4'd4, 4'd7: col = 2'd1;
            default:          col = 2'd2;
        endcase
    end

    // The scanner only looks for the glyph of the side that just moved.
    assign mover_cells = occ_q & (turn_q ? circ_q : ~circ_q);
    assign line_hit    = (mover_cells & LINE_MASK[line_idx_q]) == LINE_MASK[line_idx_q];

    always_comb begin
        state_d    = state_q;
        occ_d      = occ_q;
        circ_d     = circ_q;
        turn_d     = turn_q;
        cursor_d   = cursor_q;
        winner_d   = winner_q;
        win_mask_d = win_mask_q;
        line_idx_d = line_idx_q;
        row_n      = row;
        col_n      = col;

        unique case (state_q)
            StPlay, StWin, StDraw: begin
                if (press[BTN_START]) begin
                    state_d    = StPlay;
                    occ_d      = '0;
                    circ_d     = '0;
                    turn_d     = START_TURN;
                    cursor_d   = CURSOR_INIT;
                    winner_d   = 1'b0;
                    win_mask_d = '0;
                end else if (state_q == StPlay) begin
                    if (press[BTN_A]) begin
                        if (!occ_q[cursor_q]) begin
                            occ_d[cursor_q]  = 1'b1;
                            circ_d[cursor_q] = turn_q;
                            state_d          = StCheck;
                            line_idx_d       = '0;
                        end
                    end else begin
                        if (press[BTN_UP]) begin
                            row_n = (row == 2'd0) ? (Wrap ? 2'd2 : 2'd0) : row - 2'd1;
                        end else if (press[BTN_DOWN]) begin
                            row_n = (row == 2'd2) ? (Wrap ? 2'd0 : 2'd2) : row + 2'd1;
                        end else if (press[BTN_LEFT]) begin
                            col_n = (col == 2'd0) ? (Wrap ? 2'd2 : 2'd0) : col - 2'd1;
                        end else if (press[BTN_RIGHT]) begin
                            col_n = (col == 2'd2) ? (Wrap ? 2'd0 : 2'd2) : col + 2'd1;
                        end
                        cursor_d = cell_index(row_n, col_n);
                    end
                end
            end
            StCheck: begin
                if (line_hit) begin
                    state_d    = StWin;
                    winner_d   = turn_q;
                    win_mask_d = LINE_MASK[line_idx_q];
                end else if (line_idx_q == 3'd7) begin
                    state_d = (&occ_q) ? StDraw : StPlay;
                    turn_d  = (&occ_q) ? turn_q : ~turn_q;
                end else begin
                    line_idx_d = line_idx_q + 3'd1;
                end
            end
        endcase
    end

    always_comb begin
        cell_occupied  = occ_q;
        cell_is_circle = circ_q;
        turn           = turn_q;
        cursor         = cursor_q;
        game_state     = state_q;
        winner         = winner_q;
        win_mask       = win_mask_q;
    end

endmodule
